// File: rtl/computie_bus_capture.sv
`timescale 1ns/1ps
// Computie bus snooper: records complete bus cycles into a circular trace buffer with
// trigger and pre/post split, then streams them as bytes. Optional: CAPTURE_TIMESTAMP_EN.
module computie_bus_capture #(
  parameter int BITWIDTH     = 32,
  parameter int DEPTH        = 128,
  parameter int POST_TRIGGER = 64
) (
  input  logic                   comm_clock,
  input  logic                   reset,
  input  logic                   record_start,
  input  logic                   record_abort,
  input  logic                   record_trigger,
  input  logic                   trig_enable,
  input  logic [BITWIDTH-1:0]    trig_addr,
  input  logic [BITWIDTH-1:0]    trig_mask,
  output logic                   record_end,
  output logic                   triggered,
  output logic [$clog2(DEPTH):0] record_count,
  input  logic                   dump_start,
  output logic                   dump_end,
  output logic [7:0]             data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  input  logic                   cb_addr_strobe,
  input  logic                   cb_data_strobe,
  input  logic                   cb_read_write,
  input  logic [BITWIDTH-1:0]    cb_addr_data_bus,
  output logic                   send_receive,
  output logic                   data_dir,
  output logic                   addr_oe,
  output logic                   data_oe
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef CAPTURE_TIMESTAMP_EN
  localparam int TS_BYTES = 2;
`else
  localparam int TS_BYTES = 0;
`endif
  localparam int NB    = 1 + 2 * (BITWIDTH / 8) + TS_BYTES;
  localparam int REC_W = NB * 8;
  localparam int BYW   = $clog2(NB);

  localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]  POST_C    = CW'(POST_TRIGGER);
  localparam logic [CW-1:0]  ONE_C     = CW'(1);
  localparam logic [BYW-1:0] LAST_BYTE = BYW'(NB - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_POST, S_DONE, S_DUMP} state_t;
  typedef enum logic [1:0] {C_ADDR, C_DATA, C_SETTLE, C_WAIT} cap_t;

  state_t r_state, w_state_nx;
  cap_t   r_cap, w_cap_nx;

  logic                r_as_s1, r_as_s2, r_as_p, r_ds_s1, r_ds_s2, r_ds_p;
  logic                r_rw_s1, r_rw_s2;
  logic [BITWIDTH-1:0] r_bus_s1, r_bus_s2, r_addr;
  logic [AW-1:0]       r_ptr, r_rd_ptr;
  logic [CW-1:0]       r_count, r_post, r_rd_left;
  logic [BYW-1:0]      r_byte;
  logic                r_triggered, r_dump_end;
  logic [REC_W-1:0]    r_mem [DEPTH];
  logic [REC_W-1:0]    w_wr_rec, w_rd_rec;
  logic [7:0]          w_byte;
  logic                w_as_fall, w_as_rise, w_ds_fall, w_capturing, w_start;
  logic                w_wr, w_trig_hit, w_accept, w_last_accept;

  // NOTE: every clocked register uses non-blocking assignment so all flops update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge comm_clock) begin
    if (reset) begin
      {r_as_s1, r_as_s2, r_as_p} <= 3'b111;
      {r_ds_s1, r_ds_s2, r_ds_p} <= 3'b111;
      {r_rw_s1, r_rw_s2}         <= 2'b00;
      r_bus_s1                   <= '0;
      r_bus_s2                   <= '0;
    end else begin
      {r_as_s1, r_as_s2, r_as_p} <= {cb_addr_strobe, r_as_s1, r_as_s2};
      {r_ds_s1, r_ds_s2, r_ds_p} <= {cb_data_strobe, r_ds_s1, r_ds_s2};
      {r_rw_s1, r_rw_s2}         <= {cb_read_write, r_rw_s1};
      r_bus_s1                   <= cb_addr_data_bus;
      r_bus_s2                   <= r_bus_s1;
    end
  end

  assign w_as_fall     = r_as_p & ~r_as_s2;
  assign w_as_rise     = ~r_as_p & r_as_s2;
  assign w_ds_fall     = r_ds_p & ~r_ds_s2;
  assign w_capturing   = (r_state == S_PRE) || (r_state == S_POST);
  assign w_start       = record_start && (r_state != S_DUMP);
  assign w_wr          = w_capturing && (r_cap == C_SETTLE) && !record_start && !record_abort;
  assign w_trig_hit    = w_wr && (r_state == S_PRE) &&
                         (record_trigger || (trig_enable && (((r_addr ^ trig_addr) & trig_mask) == '0)));
  assign w_accept      = (r_state == S_DUMP) && data_ready;
  assign w_last_accept = w_accept && (r_byte == LAST_BYTE) && (r_rd_left == ONE_C);

  always_ff @(posedge comm_clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cap   <= C_ADDR;
    end else begin
      r_state <= w_state_nx;
      r_cap   <= w_cap_nx;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    w_cap_nx   = r_cap;
    if (w_start) begin
      w_state_nx = S_PRE;
      w_cap_nx   = C_ADDR;
    end else begin
      case (r_state)
        S_PRE, S_POST: begin
          if (record_abort) begin
            w_state_nx = S_DONE;
            w_cap_nx   = C_ADDR;
          end else begin
            if (w_trig_hit)                                      w_state_nx = S_POST;
            else if (r_state == S_POST && w_wr && r_post == ONE_C) w_state_nx = S_DONE;
            case (r_cap)
              C_ADDR:   if (w_as_fall) w_cap_nx = C_DATA;
              C_DATA:   if (w_as_rise) w_cap_nx = C_ADDR;
                        else if (w_ds_fall) w_cap_nx = C_SETTLE;
              C_SETTLE: w_cap_nx = C_WAIT;
              C_WAIT:   if (w_as_rise) w_cap_nx = C_ADDR;
              default:  w_cap_nx = C_ADDR;
            endcase
          end
        end
        S_DONE:  if (dump_start && r_count != '0) w_state_nx = S_DUMP;
        S_DUMP:  if (w_last_accept) w_state_nx = S_DONE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge comm_clock) begin
    if (reset) begin
      r_addr      <= '0;
      r_ptr       <= '0;
      r_count     <= '0;
      r_post      <= '0;
      r_triggered <= 1'b0;
      r_rd_ptr    <= '0;
      r_rd_left   <= '0;
      r_byte      <= '0;
      r_dump_end  <= 1'b0;
    end else begin
      r_dump_end <= 1'b0;
      if (r_cap == C_ADDR && w_as_fall) r_addr <= r_bus_s2;
      if (w_start) begin
        r_ptr       <= '0;
        r_count     <= '0;
        r_triggered <= 1'b0;
      end else begin
        if (w_wr) begin
          r_ptr <= r_ptr + AW'(1);
          if (r_count != DEPTH_C)  r_count <= r_count + ONE_C;
          if (r_state == S_POST)   r_post  <= r_post - ONE_C;
        end
        if (w_trig_hit) begin
          r_triggered <= 1'b1;
          r_post      <= POST_C;
        end
        if (r_state == S_DONE && dump_start) begin
          if (r_count == '0) begin
            r_dump_end <= 1'b1;
          end else begin
            // Oldest record sits count slots behind the write pointer, modulo DEPTH.
            r_rd_ptr  <= r_ptr - r_count[AW-1:0];
            r_rd_left <= r_count;
            r_byte    <= '0;
          end
        end
        if (w_accept) begin
          if (r_byte == LAST_BYTE) begin
            r_byte    <= '0;
            r_rd_ptr  <= r_rd_ptr + AW'(1);
            r_rd_left <= r_rd_left - ONE_C;
            if (r_rd_left == ONE_C) r_dump_end <= 1'b1;
          end else begin
            r_byte <= r_byte + BYW'(1);
          end
        end
      end
    end
  end

`ifdef CAPTURE_TIMESTAMP_EN
  logic [15:0] r_ts;
  always_ff @(posedge comm_clock) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 16'd1;
  end
  assign w_wr_rec = {w_trig_hit, 1'b1, 5'b0, r_rw_s2, r_addr, r_bus_s2, r_ts};
`else
  assign w_wr_rec = {w_trig_hit, 1'b0, 5'b0, r_rw_s2, r_addr, r_bus_s2};
`endif

  // NOTE: the trace buffer is deliberately left out of reset; record_count alone says
  // which slots hold valid records.
  always_ff @(posedge comm_clock) begin
    if (w_wr) r_mem[r_ptr] <= w_wr_rec;
  end

  assign w_rd_rec = r_mem[r_rd_ptr];

  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NB; i++)
      if (r_byte == BYW'(i)) w_byte = w_rd_rec[(NB-1-i)*8 +: 8];
  end

  assign data_out     = (r_state == S_DUMP) ? w_byte : 8'h00;
  assign data_valid   = (r_state == S_DUMP);
  assign dump_end     = r_dump_end;
  assign record_end   = (r_state == S_DONE) || (r_state == S_DUMP);
  assign triggered    = r_triggered;
  assign record_count = r_count;
  assign addr_oe      = w_capturing && (r_cap == C_ADDR || r_cap == C_DATA);
  assign data_oe      = w_capturing && (r_cap == C_SETTLE || r_cap == C_WAIT);
  assign send_receive = 1'b0;
  assign data_dir     = 1'b0;
endmodule

// File: tb/tb_computie_bus_capture.sv
`timescale 1ns/1ps
// Directed bench for computie_bus_capture: a transaction-level capture model predicts
// record counts, trigger state and the dumped byte stream, checked every valid cycle.
module tb_computie_bus_capture;
  localparam int BW = 32, DEPTH = 8, POST = 2;

  logic        comm_clock = 1'b0, reset = 1'b1;
  logic        record_start = 0, record_abort = 0, record_trigger = 0, trig_enable = 0;
  logic [31:0] trig_addr = '0, trig_mask = '0;
  logic        record_end, triggered, dump_end, data_valid, send_receive, data_dir, addr_oe, data_oe;
  logic [3:0]  record_count;
  logic        dump_start = 0, data_ready = 0;
  logic [7:0]  data_out;
  logic        cb_addr_strobe = 1, cb_data_strobe = 1, cb_read_write = 0;
  logic [31:0] cb_addr_data_bus = '0;

  computie_bus_capture #(.BITWIDTH(BW), .DEPTH(DEPTH), .POST_TRIGGER(POST)) dut (
    .comm_clock(comm_clock), .reset(reset), .record_start(record_start),
    .record_abort(record_abort), .record_trigger(record_trigger), .trig_enable(trig_enable),
    .trig_addr(trig_addr), .trig_mask(trig_mask), .record_end(record_end),
    .triggered(triggered), .record_count(record_count), .dump_start(dump_start),
    .dump_end(dump_end), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .cb_addr_strobe(cb_addr_strobe), .cb_data_strobe(cb_data_strobe),
    .cb_read_write(cb_read_write), .cb_addr_data_bus(cb_addr_data_bus),
    .send_receive(send_receive), .data_dir(data_dir), .addr_oe(addr_oe), .data_oe(data_oe));

  always #5 comm_clock = ~comm_clock;

  typedef struct { logic [31:0] a; logic [31:0] d; bit rw; bit tr; } rec_t;
  rec_t       m_q[$];
  logic [7:0] exp_q[$];
  int         m_state = 0;  // 0 idle, 1 pre-trigger, 2 post-trigger, 3 done
  bit         m_trig = 0;
  int         m_post = 0;
  int         n_vec = 0, n_err = 0, n_rx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge comm_clock);
    #2;
  endtask

  function automatic bit capturing();
    return (m_state == 1) || (m_state == 2);
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input bit rw, input bit ext);
    rec_t r;
    if (!capturing()) return;
    r.a = a; r.d = d; r.rw = rw;
    r.tr = (m_state == 1) && (ext || (trig_enable && (((a ^ trig_addr) & trig_mask) == 0)));
    m_q.push_back(r);
    if (m_q.size() > DEPTH) void'(m_q.pop_front());
    if (r.tr) begin
      m_trig = 1; m_state = 2; m_post = POST;
    end else if (m_state == 2) begin
      m_post--;
      if (m_post == 0) m_state = 3;
    end
  endtask

  task automatic build_exp();
    exp_q.delete();
    foreach (m_q[i]) begin
      exp_q.push_back({m_q[i].tr, 6'b0, m_q[i].rw});
      for (int b = 3; b >= 0; b--) exp_q.push_back(m_q[i].a[b*8 +: 8]);
      for (int b = 3; b >= 0; b--) exp_q.push_back(m_q[i].d[b*8 +: 8]);
    end
  endtask

  task automatic do_start();
    record_start = 1; tick(1); record_start = 0; tick(1);
    m_q.delete(); m_state = 1; m_trig = 0;
  endtask

  task automatic do_abort();
    record_abort = 1; tick(1); record_abort = 0; tick(1);
    if (capturing()) m_state = 3;
  endtask

  task automatic check_status(input string tag);
    @(negedge comm_clock);
    check({tag, "_count"}, record_count, m_q.size());
    check({tag, "_triggered"}, triggered, m_trig);
    check({tag, "_record_end"}, record_end, m_state == 3);
    check({tag, "_addr_oe"}, addr_oe, capturing());
    tick(1);
  endtask

  task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input bit rw,
                           input bit ext, input bit has_ds);
    cb_addr_data_bus = a; cb_read_write = rw; tick(2);
    cb_addr_strobe = 0; tick(5);
    if (has_ds) begin
      cb_addr_data_bus = d; tick(2);
      record_trigger = ext; cb_data_strobe = 0; tick(6);
      record_trigger = 0;
      model_store(a, d, rw, ext);
      @(negedge comm_clock);
      check("data_oe", data_oe, capturing());
      tick(1);
    end
    cb_addr_strobe = 1; cb_data_strobe = 1; tick(5);
  endtask

  // Compare process: every accepted byte against the model stream, every stall for hold.
  logic [7:0] prev_byte = '0;
  bit         prev_stall = 0;
  always @(negedge comm_clock) begin
    logic [7:0] e;
    if (data_valid && prev_stall) check("hold_byte", data_out, prev_byte);
    if (data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL extra_byte: got 0x%0h, expected no byte", data_out);
      end else begin
        e = exp_q.pop_front();
        check("stream_byte", data_out, e);
      end
      n_rx++;
    end
    prev_stall = data_valid && !data_ready;
    prev_byte  = data_out;
  end

  task automatic run_dump(input bit toggle, input int exp_len, input bit poke_start);
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int rx0 = n_rx, cyc = 0;
    bit got = 0;
    check("model_len", exp_q.size(), exp_len);
    data_ready = !toggle;
    dump_start = 1; tick(1); dump_start = 0;
    if (poke_start && exp_len != 0) begin
      data_ready = 0; record_start = 1; tick(1); record_start = 0;
      @(negedge comm_clock);
      check("start_ignored_valid", data_valid, 1);
      check("start_ignored_count", record_count, m_q.size());
      tick(1);
    end
    while (!got && cyc < 2000) begin
      data_ready = toggle ? pat[cyc % 4] : 1'b1;
      @(negedge comm_clock);
      if (dump_end) got = 1;
      else begin
        tick(1); cyc++;
      end
    end
    check("dump_end_seen", got, 1);
    check("bytes_left", exp_q.size(), 0);
    check("bytes_received", n_rx - rx0, exp_len);
    tick(1); data_ready = 0;
    @(negedge comm_clock);
    check("dump_end_pulse", dump_end, 0);
    check("valid_after_dump", data_valid, 0);
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    @(negedge comm_clock);
    check("rst_record_end", record_end, 0);
    check("rst_triggered", triggered, 0);
    check("rst_count", record_count, 0);
    check("rst_valid", data_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_oe", {addr_oe, data_oe, dump_end}, 0);
    check("rst_dir", {send_receive, data_dir}, 0);
    reset = 0; tick(2);

    // Three read cycles, abort, full-rate dump then a throttled repeat dump.
    do_start();
    @(negedge comm_clock);
    check("armed_addr_oe", addr_oe, 1);
    check("armed_data_oe", data_oe, 0);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      bus_cycle(32'h1000 + 32'(i * 4), 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1);
      check_status("t1");
    end
    do_abort();
    check_status("t1_abort");
    check("t1_count_lit", record_count, 3);
    build_exp();
    check("t1_b0", exp_q[0], 8'h01);
    check("t1_b3", exp_q[3], 8'h10);
    check("t1_b5", exp_q[5], 8'hA5);
    run_dump(1'b0, 27, 1'b0);
    build_exp();
    run_dump(1'b1, 27, 1'b1);
    check_status("t1_after");

    // Address-match trigger with wrap: AS-only cycle first, then 20 cycles.
    trig_enable = 1; trig_addr = 32'h2000; trig_mask = 32'hFFFF_FFFF;
    do_start();
    bus_cycle(32'h0040, 32'h0, 1'b0, 1'b0, 1'b0);
    check_status("as_only");
    for (int i = 0; i < 20; i++) begin
      bus_cycle((i == 12) ? 32'h2000 : 32'(i * 4), 32'hD000_0000 | 32'(i), i[0], 1'b0, 1'b1);
      check_status("t2");
    end
    check("t2_count_lit", record_count, 8);
    check("t2_trig_lit", triggered, 1);
    build_exp();
    check("t2_oldest_addr", exp_q[4], 8'h1C);
    check("t2_trig_flags", exp_q[45], 8'h80);
    run_dump(1'b1, 72, 1'b0);

    // External trigger on the third record.
    trig_enable = 0;
    do_start();
    for (int i = 0; i < 6; i++) begin
      bus_cycle(32'h3000 + 32'(i * 4), 32'h5555_0000 | 32'(i), i[0], i == 2, 1'b1);
      check_status("t3");
    end
    build_exp();
    check("t3_trig_flags", exp_q[18], 8'h80);
    run_dump(1'b0, 45, 1'b0);

    // Empty buffer dump.
    do_start();
    do_abort();
    check_status("t4");
    build_exp();
    run_dump(1'b0, 0, 1'b0);

    // Reset in the middle of post-trigger capture.
    do_start();
    bus_cycle(32'h4000, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
    check_status("t5_post");
    reset = 1;
    @(posedge comm_clock);
    @(negedge comm_clock);
    check("t5_record_end", record_end, 0);
    check("t5_triggered", triggered, 0);
    check("t5_addr_oe", addr_oe, 0);
    check("t5_count", record_count, 0);
    reset = 0; m_q.delete(); m_state = 0; m_trig = 0;
    tick(2);
    check_status("t5_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/computie_bus_capture.md
Name: computie_bus_capture

Overview:
- Second-generation Computie bus snooper.
- Passively records complete bus cycles (address, data, R/W) into a circular buffer with a programmable trigger and pre/post-trigger split.
- Streams the captured records out as bytes over a valid/ready handshake to the comm/serial layer.
- Runs entirely in the comm clock domain; bus control inputs pass through 2-FF synchronisers.

Parameters:
- BITWIDTH, 32, width of the multiplexed address/data bus; must be a multiple of 8.
- DEPTH, 128, number of record slots; power of 2, minimum 4.
- POST_TRIGGER, 64, records stored after the trigger cycle; range 1..DEPTH-1.

Ports:
- comm_clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- record_start  in  1  pulse: clear buffer and arm capture.
- record_abort  in  1  pulse: stop capture immediately and go to DONE.
- record_trigger  in  1  external trigger, level; sampled each cycle while armed.
- trig_enable  in  1  enables address-match trigger.
- trig_addr  in  BITWIDTH  address match value.
- trig_mask  in  BITWIDTH  1 = bit compared.
- record_end  out  1  level; high in DONE.
- triggered  out  1  level; high from trigger until the next record_start or reset.
- record_count  out  $clog2(DEPTH)+1  valid records held, saturating at DEPTH.
- dump_start  in  1  pulse: begin byte stream; honoured only in DONE.
- dump_end  out  1  one-cycle pulse after the last byte is accepted.
- data_out  out  8  stream byte.
- data_valid  out  1  data_out valid.
- data_ready  in  1  consumer accepts byte when valid && ready.
- cb_addr_strobe  in  1  active-low, asynchronous.
- cb_data_strobe  in  1  active-low, asynchronous.
- cb_read_write  in  1  1 = read.
- cb_addr_data_bus  in  BITWIDTH  multiplexed bus, asynchronous.
- send_receive, data_dir  out  1 each  constant 0 (receive).
- addr_oe, data_oe  out  1 each  transceiver enables.

Behaviour:
- Reset values:
  - Outputs: record_end=0, triggered=0, record_count=0, dump_end=0, data_valid=0, data_out=0, addr_oe=0, data_oe=0.
  - Internal: state=IDLE, write pointer=0.
- Synchronisers: AS, DS, R/W and the bus each pass through 2 FFs. Edges are detected on the synchronised strobes; worst-case latency is 3 clocks.
- Top FSM, IDLE -> PRE -> POST -> DONE -> DUMP -> DONE:
  - IDLE: no capture.
  - record_start, from any state except DUMP: clear pointer, count and triggered; go to PRE.
  - PRE: records write circularly. Count saturates at DEPTH; the write pointer wraps modulo DEPTH, overwriting the oldest record.
  - Trigger event in PRE: the stored cycle has a masked address match ((addr ^ trig_addr) & trig_mask)==0 with trig_enable=1, or record_trigger=1 on the cycle the record is written. On that event:
    - Set triggered.
    - Load the post counter with POST_TRIGGER.
    - The trigger record itself counts as pre-trigger.
    - Go to POST.
  - POST: each stored record decrements the post counter; at 0, go to DONE.
  - record_abort in PRE or POST: go to DONE at once; a partially captured cycle is discarded.
- Cycle capture sub-FSM (active in PRE/POST):
  - C_ADDR (addr_oe=1, data_oe=0): on AS falling edge, latch the synced bus as address and go to C_DATA.
  - C_DATA: on DS falling edge, set addr_oe=0, data_oe=1 and go to C_SETTLE. If AS rises first, discard the cycle and return to C_ADDR.
  - C_SETTLE: wait 1 clock, latch data and R/W, write the record and go to C_WAIT.
  - C_WAIT: on AS rising edge, set addr_oe=1, data_oe=0 and go to C_ADDR.
  - Outside PRE/POST: addr_oe=data_oe=0.
- Simultaneous events:
  - record_start wins over record_abort and trigger.
  - A record write and a trigger in the same cycle: the record is written, then the trigger takes effect.
- Dump, started by dump_start in DONE:
  - Emit record_count records, oldest first. Oldest = pointer-count mod DEPTH.
  - Per record, the byte sequence is:
    - flags byte {triggered_here, 6'b0, rw};
    - address, MSB byte first;
    - data, MSB byte first.
    - So BITWIDTH/4+1 bytes per record.
  - data_out and data_valid are held stable until accepted; the next byte is presented the cycle after the handshake.
  - When record_count=0, dump_end pulses 1 cycle after dump_start and no bytes are sent.
  - After the last byte, pulse dump_end and return to DONE; records are retained, so the dump is repeatable.
  - record_start during DUMP is ignored.
- reset mid-operation: returns to IDLE in one cycle; buffer contents are undefined.

Optional Feature:
- CAPTURE_TIMESTAMP_EN defined:
  - A free-running 16-bit cycle counter (reset 0, wraps) is stored with each record at C_SETTLE.
  - The dump appends 2 timestamp bytes, MSB first, per record.
  - flags bit 6 = 1.
- Undefined: no counter and no extra bytes; flags bit 6 = 0.

Test Plan:
- Reset, then record_start, 3 bus cycles (addr 0x1000/0x1004/0x1008, data 0xA5A5A5A5.., rw=1), record_abort, dump with ready=1 -> record_count=3; 27 bytes, first 0x01,0x00,0x00,0x10,0x00,0xA5..; dump_end one pulse.
- DEPTH=8, POST_TRIGGER=2, trig_addr=0x2000, mask=0xFFFFFFFF, 20 cycles with addrs 0x0..0x13*4 with one at 0x2000 as cycle 12 -> triggered=1, capture ends after cycle 14, count=8, dump oldest=cycle 7, trigger record flags bit7=1.
- AS asserted then released with no DS -> no record written, count unchanged, addr_oe stays 1.
- data_ready toggles 1-0-0-1 during dump -> data_out held constant while ready=0, no byte lost or duplicated.
- Reset asserted mid-POST -> next cycle record_end=0, triggered=0, addr_oe=0, count=0.
- CAPTURE_TIMESTAMP_EN, 2 cycles 10 clocks apart -> 11 bytes/record, timestamps differ by 10.
